// File: rtl/inv_pkg.sv
// Shared types and defaults for the inv_pipe elastic inverter.
package inv_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INV  = 2'b01,
    MODE_MASK = 2'b10,
    MODE_ALT  = 2'b11
  } mode_t;

endpackage

// File: rtl/inv_stage.sv
// One elastic register slot: holds a beat until downstream takes it, and
// accepts a new beat whenever it is empty or emptying this cycle.
module inv_stage
  import inv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_up_valid,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_up_ready,
  output logic             o_dn_valid,
  output logic [WIDTH-1:0] o_dn_data,
  input  logic             i_dn_ready
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Ready chains combinationally so a full pipe drains without a bubble.
  assign o_up_ready = !r_valid || i_dn_ready;
  assign o_dn_valid = r_valid;
  assign o_dn_data  = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_up_ready) begin
      r_valid <= i_up_valid;
      if (i_up_valid) begin
        r_data <= i_up_data;
      end
    end
  end

endmodule

// File: rtl/inv_pipe.sv
// Pipelined bitwise inverter: per-beat transform at entry, then a chain of
// STAGES elastic slots with valid/ready on both sides.
module inv_pipe
  import inv_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_ready;
  logic [WIDTH-1:0] w_data [0:STAGES];
  logic [WIDTH-1:0] w_xform;
  logic             w_accept;
  mode_t            w_mode;
  logic             r_parity;

  assign w_mode   = mode_t'(mode);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_xform = in_data;
    case (w_mode)
      MODE_PASS: w_xform = in_data;
      MODE_INV:  w_xform = ~in_data;
      MODE_MASK: w_xform = in_data ^ mask;
      MODE_ALT:  w_xform = r_parity ? ~in_data : in_data;
      default:   w_xform = in_data;
    endcase
  end

  // Parity counts every accepted beat regardless of mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ~r_parity;
    end
  end

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = w_xform;
  assign w_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    inv_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .i_up_valid (w_valid[k]),
      .i_up_data  (w_data[k]),
      .o_up_ready (w_ready[k]),
      .o_dn_valid (w_valid[k+1]),
      .o_dn_data  (w_data[k+1]),
      .i_dn_ready (w_ready[k+1])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[STAGES];
  assign out_data  = w_data[STAGES];
  assign busy      = |w_valid[STAGES:1];

endmodule

// File: tb/tb_inv_pipe.sv
// Scoreboard bench for inv_pipe: directed scenarios plus random traffic,
// with a reference model that derives each expected beat from the mode rules.
module tb_inv_pipe;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   mode;
  logic [W-1:0] mask;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc_cnt = 0;
  bit   lat_exact = 1'b1;
  bit   m_parity = 1'b0;

  inv_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .mask      (mask),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_xf(input logic [1:0] m, input logic [W-1:0] mk,
                                          input logic [W-1:0] d, input bit p);
    logic [W-1:0] all_ones;
    all_ones = '1;
    case (m)
      2'd0:    return d;
      2'd1:    return all_ones - d;
      2'd2:    return d ^ mk;
      default: return p ? (all_ones - d) : d;
    endcase
  endfunction

  // Reference model: every accepted beat pushes its expected output.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) begin
      q.delete();
      m_parity = 1'b0;
    end else if (in_valid && in_ready) begin
      e.data = ref_xf(mode, mask, in_data, m_parity);
      e.cyc  = cyc_cnt;
      q.push_back(e);
      m_parity = !m_parity;
    end
  end

  // Monitor: compare emitted beats, latency and hold-under-backpressure.
  initial begin
    bit           prev_stall;
    logic [W-1:0] prev_data;
    exp_t         e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          cmp("hold_valid", out_valid, 1);
          cmp("hold_data", out_data, prev_data);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL spurious_beat: got 0x%0h, expected no beat (t=%0t)", out_data, $time);
          end else begin
            e = q.pop_front();
            cmp("out_data", out_data, e.data);
            if (lat_exact) cmp("latency", cyc_cnt - e.cyc, S);
            else           cmp("min_latency", (cyc_cnt - e.cyc) >= S, 1);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h66;
    cyc();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 60 && (q.size() != 0 || busy); i++) cyc();
    cyc();
    cmp("drain_queue", q.size(), 0);
    cmp("drain_busy", busy, 0);
  endtask

  logic [W-1:0] alt_exp  [6];
  logic [1:0]   alt_mode [6];

  initial begin
    alt_exp  = '{8'h3C, 8'hC3, 8'h3C, 8'h3C, 8'h3C, 8'hC3};
    alt_mode = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3};

    // Reset held two cycles with input offered.
    reset = 1'b1; mode = 2'd0; mask = 8'h00; in_valid = 1'b1;
    in_data = 8'h77; out_ready = 1'b1;
    cyc(); cyc();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_busy", busy, 0);
    cmp("rst_in_ready", in_ready, 1);
    cmp("rst_out_data", out_data, 8'h00);
    cyc(); cyc();
    cmp("rst_no_emit", out_valid, 0);

    // Invert, back-to-back.
    mode = 2'd1; in_valid = 1'b1; in_data = 8'h00;
    cyc();
    in_data = 8'h5A;
    cyc();
    in_valid = 1'b0;
    cmp("inv_first", out_data, 8'hFF);
    cmp("inv_first_v", out_valid, 1);
    cyc();
    cmp("inv_second", out_data, 8'hA5);
    cmp("inv_second_v", out_valid, 1);
    drain();

    // Mask changes while a beat is in flight.
    mode = 2'd2; mask = 8'h0F; in_valid = 1'b1; in_data = 8'hA5;
    cyc();
    mask = 8'hF0;
    cyc();
    in_valid = 1'b0;
    cmp("mask_first", out_data, 8'hAA);
    cyc();
    cmp("mask_second", out_data, 8'h55);
    drain();

    // Alternate mode; parity keeps counting through a pass beat.
    do_reset();
    in_data = 8'h3C;
    for (int k = 0; k < 7; k++) begin
      if (k < 6) begin
        mode = alt_mode[k];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (k >= 1) cmp("alt_out", out_data, alt_exp[k-1]);
    end
    drain();

    // Backpressure: capacity, then bubble-free drain.
    lat_exact = 1'b0;
    mode = 2'd0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    #1 cmp("bp_ready_1", in_ready, 1);
    cyc();
    in_data = 8'h02;
    #1 cmp("bp_ready_2", in_ready, 1);
    cyc();
    in_data = 8'h03;
    #1 cmp("bp_full_ready", in_ready, 0);
    cmp("bp_busy", busy, 1);
    cyc();
    #1 cmp("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    #1 cmp("bp_drain_ready_3", in_ready, 1);
    cyc();
    in_data = 8'h04;
    #1 cmp("bp_drain_ready_4", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    drain();

    // Mid-stream reset with parity left at 1.
    mode = 2'd0; in_valid = 1'b1; in_data = 8'h99;
    cyc();
    drain();
    mode = 2'd3; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    cyc();
    in_data = 8'h22;
    cyc();
    reset = 1'b1; in_data = 8'h33;
    cyc();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    cmp("mid_rst_out_valid", out_valid, 0);
    cmp("mid_rst_busy", busy, 0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h3C;
    cyc();
    in_valid = 1'b0;
    cyc();
    cmp("mid_rst_parity", out_data, 8'h3C);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      mode      = 2'($urandom_range(0, 3));
      mask      = 8'($urandom);
      in_data   = 8'($urandom);
      cyc();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
